// File: rtl/if_id_pkg.sv
// Shared widths, the RV32I NOP encoding and the state encoding for the
// fetch/decode pipeline register and its skid pair.
package if_id_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFID_EMPTY = 2'd0,
        IFID_BUSY  = 2'd1,
        IFID_FULL  = 2'd2
    } ifid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry pipeline register with skid buffer and flush.
// The output register drives the outputs directly; the skid register
// catches the one item that arrives while downstream stalls. Every
// register that does not hold a valid item is parked at RESET_VAL, so
// the outputs read RESET_VAL whenever out_valid is low.
module pipe_skid_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    import if_id_pkg::*;

    ifid_state_e      state;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             accept;
    logic             take;

    // Handshakes are pure decodes of the state register, so ready toward
    // the producer never depends combinationally on out_ready.
    assign in_ready  = (state != IFID_FULL);
    assign out_valid = (state != IFID_EMPTY);
    assign out_data  = out_reg;
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    // State machine and both payload registers; flush outranks everything
    // and a same-cycle take is simply treated as consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IFID_EMPTY;
            out_reg  <= RESET_VAL;
            skid_reg <= RESET_VAL;
        end else if (flush) begin
            state    <= IFID_EMPTY;
            out_reg  <= RESET_VAL;
            skid_reg <= RESET_VAL;
        end else begin
            case (state)
                IFID_EMPTY: begin
                    if (accept) begin
                        out_reg <= in_data;
                        state   <= IFID_BUSY;
                    end
                end
                IFID_BUSY: begin
                    if (accept && take) begin
                        out_reg <= in_data;
                    end else if (accept) begin
                        skid_reg <= in_data;
                        state    <= IFID_FULL;
                    end else if (take) begin
                        out_reg <= RESET_VAL;
                        state   <= IFID_EMPTY;
                    end
                end
                IFID_FULL: begin
                    if (take) begin
                        out_reg  <= skid_reg;
                        skid_reg <= RESET_VAL;
                        state    <= IFID_BUSY;
                    end
                end
                default: begin
                    state    <= IFID_EMPTY;
                    out_reg  <= RESET_VAL;
                    skid_reg <= RESET_VAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_id.sv
// Instruction fetch to decode pipeline register. Wraps the generic skid
// pair around an {address, instruction} payload; ready_out doubles as the
// PC advance enable for pc_reg, and flush_in turns everything held into
// NOPs on a taken jump.
module if_id
    import if_id_pkg::*;
#(
    parameter logic [INST_W-1:0]      NOP_INST   = INST_NOP,
    parameter logic [INST_ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] inst_addr_in,
    input  logic [INST_W-1:0]      inst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   flush_in,
    output logic [INST_ADDR_W-1:0] inst_addr_out,
    output logic [INST_W-1:0]      inst_out,
    output logic                   valid_out,
    input  logic                   ready_in
);

    localparam int PAYLOAD_W = INST_ADDR_W + INST_W;
    localparam logic [PAYLOAD_W-1:0] PAYLOAD_RESET = {RESET_ADDR, NOP_INST};

    logic [PAYLOAD_W-1:0] payload_in;
    logic [PAYLOAD_W-1:0] payload_out;

    assign payload_in = {inst_addr_in, inst_in};

    pipe_skid_reg #(
        .WIDTH     (PAYLOAD_W),
        .RESET_VAL (PAYLOAD_RESET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_in),
        .in_data   (payload_in),
        .in_valid  (valid_in),
        .in_ready  (ready_out),
        .out_data  (payload_out),
        .out_valid (valid_out),
        .out_ready (ready_in)
    );

    assign inst_addr_out = payload_out[PAYLOAD_W-1:INST_W];
    assign inst_out      = payload_out[INST_W-1:0];

endmodule
